// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares the single write port of an async FIFO
//   among NumReq valid/ready producers. A grant lasts until MaxBurst beats have
//   transferred or the granted producer drops valid. A new grant can follow
//   the old one in the same cycle, so there is no IDLE bubble between them.
//   The FIFO write handshake is forwarded combinationally and carries a
//   source-ID tag. All logic is in the FIFO write-clock domain.
//
// Ports
//   clk_i          clock, posedge
//   reset_ni       asynchronous active-low reset
//   req_valid_i    per-requester valid
//   req_ready_o    per-requester ready (one-hot or zero)
//   req_data_i     packed payloads, requester k at [k*DataWidth +: DataWidth]
//   fifo_wvalid_o  FIFO write valid
//   fifo_wready_i  FIFO write ready
//   fifo_data_o    FIFO write data
//   fifo_src_o     index of the granted requester
//   grant_o        registered one-hot grant
//   busy_o         high while a grant is active
//
// State table
//   ST_IDLE  | no grant; arbitrate among valid requesters from ptr+1
//   ST_GRANT | src_q owns the FIFO write port; beats counted in beat_q

module fifo_wr_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 4,
  parameter int MaxBurst  = 4,
  localparam int IdWidth  = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic                          fifo_wvalid_o,
  input  logic                          fifo_wready_i,
  output logic [DataWidth-1:0]          fifo_data_o,
  output logic [IdWidth-1:0]            fifo_src_o,
  output logic [NumReq-1:0]             grant_o,
  output logic                          busy_o
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [7:0] LastBeat = 8'(MaxBurst - 1);

  state_t               state_q, state_d;
  logic [IdWidth-1:0]   src_q, src_d;
  logic [IdWidth-1:0]   ptr_q, ptr_d;
  logic [NumReq-1:0]    grant_q, grant_d;
  logic [7:0]           beat_q, beat_d;

  logic                 sel_valid;
  logic [DataWidth-1:0] sel_data;
  logic                 xfer;
  logic                 rel_now;
  logic                 pick_ok;
  logic [IdWidth-1:0]   pick_idx;

  // First set bit of vld searching upward from last+1, wrapping. The loop runs
  // from the farthest candidate to the nearest so the nearest one wins. Only
  // indices below NumReq are produced.
  function automatic logic [IdWidth:0] rr_pick(input logic [NumReq-1:0]  vld,
                                               input logic [IdWidth-1:0] last);
    logic [IdWidth:0]   res;
    logic [IdWidth-1:0] idx_w;
    int                 idx;
    res = '0;
    for (int i = NumReq; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      idx_w = idx[IdWidth-1:0];
      if (vld[idx_w]) res = {1'b1, idx_w};
    end
    return res;
  endfunction

  function automatic logic [NumReq-1:0] onehot(input logic [IdWidth-1:0] idx);
    logic [NumReq-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Mux of the granted channel
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (src_q == IdWidth'(k)) begin
        sel_valid = req_valid_i[k];
        sel_data  = req_data_i[k*DataWidth +: DataWidth];
      end
    end
  end

  assign xfer    = (state_q == ST_GRANT) && sel_valid && fifo_wready_i;
  // Release on the last beat of a burst, or at once if the owner goes idle.
  // A stalled beat (valid, no ready) holds the grant indefinitely.
  assign rel_now = (state_q == ST_GRANT) &&
                   (!sel_valid || (xfer && (beat_q == LastBeat)));

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      ptr_q   <= IdWidth'(NumReq - 1);
      grant_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    pick_ok  = 1'b0;
    pick_idx = '0;
    case (state_q)
      ST_IDLE: begin
        {pick_ok, pick_idx} = rr_pick(req_valid_i, ptr_q);
        if (pick_ok) begin
          state_d = ST_GRANT;
          src_d   = pick_idx;
          grant_d = onehot(pick_idx);
          beat_d  = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) beat_d = beat_q + 8'd1;
        if (rel_now) begin
          ptr_d  = src_q;
          beat_d = '0;
          // The released owner is masked out; if it is the only one still
          // valid it is re-granted through IDLE.
          {pick_ok, pick_idx} = rr_pick(req_valid_i & ~grant_q, src_q);
          if (pick_ok) begin
            src_d   = pick_idx;
            grant_d = onehot(pick_idx);
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy_o        = (state_q == ST_GRANT);
    fifo_wvalid_o = busy_o && sel_valid;
    fifo_data_o   = busy_o ? sel_data : '0;
    req_ready_o   = busy_o ? (grant_q & {NumReq{fifo_wready_i}}) : '0;
    fifo_src_o    = src_q;
    grant_o       = grant_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks for fifo_wr_arbiter with NumReq=4,
// DataWidth=4, MaxBurst=4.

module tb_fifo_wr_arbiter;

  localparam int NumReq    = 4;
  localparam int DataWidth = 4;
  localparam int MaxBurst  = 4;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic [NumReq-1:0]           req_valid;
  logic [NumReq-1:0]           req_ready;
  logic [NumReq*DataWidth-1:0] req_data;
  logic                        fifo_wvalid;
  logic                        fifo_wready;
  logic [DataWidth-1:0]        fifo_data;
  logic [1:0]                  fifo_src;
  logic [NumReq-1:0]           grant;
  logic                        busy;

  logic [DataWidth-1:0]        dat [NumReq];

  int n_checks = 0;
  int n_pass   = 0;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NumReq    (NumReq),
    .DataWidth (DataWidth),
    .MaxBurst  (MaxBurst)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_data_i    (req_data),
    .fifo_wvalid_o (fifo_wvalid),
    .fifo_wready_i (fifo_wready),
    .fifo_data_o   (fifo_data),
    .fifo_src_o    (fifo_src),
    .grant_o       (grant),
    .busy_o        (busy)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    req_valid   = '0;
    fifo_wready = 1'b1;
    repeat (2) cyc();
    reset_n = 1'b1;
  endtask

  int seq [NumReq];
  int beats;
  int fifo_hs;
  int cycles;

  initial begin
    reset_n     = 1'b0;
    req_valid   = 4'b1111;
    fifo_wready = 1'b1;
    for (int k = 0; k < NumReq; k++) dat[k] = 4'(k + 1);

    // Outputs held at zero while in reset even with traffic present
    #12;
    chk_eq("rst_busy",   32'(busy),        32'd0);
    chk_eq("rst_grant",  32'(grant),       32'd0);
    chk_eq("rst_src",    32'(fifo_src),    32'd0);
    chk_eq("rst_wvalid", 32'(fifo_wvalid), 32'd0);
    chk_eq("rst_ready",  32'(req_ready),   32'd0);
    chk_eq("rst_data",   32'(fifo_data),   32'd0);

    // T1: single requester, three beats, then back to IDLE
    do_reset();
    req_valid = 4'b0001;
    dat[0]    = 4'd5;
    #1;
    chk_eq("t1_idle_busy",   32'(busy),        32'd0);
    chk_eq("t1_idle_wvalid", 32'(fifo_wvalid), 32'd0);
    for (int b = 0; b < 3; b++) begin
      cyc();
      dat[0] = 4'(5 + b);
      #1;
      chk_eq("t1_src",    32'(fifo_src),    32'd0);
      chk_eq("t1_grant",  32'(grant),       32'h1);
      chk_eq("t1_wvalid", 32'(fifo_wvalid), 32'd1);
      chk_eq("t1_data",   32'(fifo_data),   32'(5 + b));
      chk_eq("t1_ready",  32'(req_ready),   32'h1);
    end
    cyc();
    req_valid = '0;
    #1;
    chk_eq("t1_drop_busy",   32'(busy),        32'd1);
    chk_eq("t1_drop_wvalid", 32'(fifo_wvalid), 32'd0);
    cyc();
    #1;
    chk_eq("t1_end_busy",  32'(busy),      32'd0);
    chk_eq("t1_end_grant", 32'(grant),     32'd0);
    chk_eq("t1_end_src",   32'(fifo_src),  32'd0);
    chk_eq("t1_end_data",  32'(fifo_data), 32'd0);

    // T2: all valid, order 0,1,2,3,0 with 4 beats each and no bubble
    do_reset();
    for (int k = 0; k < NumReq; k++) dat[k] = 4'(k + 1);
    req_valid = 4'b1111;
    #1;
    chk_eq("t2_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 17; i++) begin
      cyc();
      #1;
      chk_eq("t2_src",    32'(fifo_src),    32'((i / 4) % 4));
      chk_eq("t2_wvalid", 32'(fifo_wvalid), 32'd1);
      chk_eq("t2_data",   32'(fifo_data),   32'(((i / 4) % 4) + 1));
      chk_eq("t2_ready",  32'(req_ready),   32'(1 << ((i / 4) % 4)));
    end

    // T3: back-pressure after 8 beats, then a single beat released
    do_reset();
    dat[0]    = 4'hA;
    dat[1]    = 4'hB;
    req_valid = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      cyc();
      #1;
      chk_eq("t3_fill_src", 32'(fifo_src), 32'(i / 4));
    end
    cyc();
    fifo_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_eq("t3_stall_grant",  32'(grant),       32'h1);
      chk_eq("t3_stall_wvalid", 32'(fifo_wvalid), 32'd1);
      chk_eq("t3_stall_ready",  32'(req_ready),   32'd0);
      chk_eq("t3_stall_data",   32'(fifo_data),   32'hA);
      cyc();
    end
    fifo_wready = 1'b1;
    #1;
    chk_eq("t3_one_ready", 32'(req_ready), 32'h1);
    cyc();
    fifo_wready = 1'b0;
    #1;
    chk_eq("t3_after_ready", 32'(req_ready), 32'd0);
    chk_eq("t3_after_src",   32'(fifo_src),  32'd0);
    cyc();
    fifo_wready = 1'b1;
    // One beat already taken, so three more for requester 0, then requester 1
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_eq("t3_rest_src", 32'(fifo_src), 32'(i < 3 ? 0 : 1));
      cyc();
    end

    // T4: requester 2 drops valid after 2 beats while requester 1 waits
    do_reset();
    dat[2]    = 4'hC;
    req_valid = 4'b0100;
    cyc();
    req_valid = 4'b0110;
    #1;
    chk_eq("t4_src2", 32'(fifo_src), 32'd2);
    cyc();
    cyc();
    req_valid = 4'b0010;
    #1;
    chk_eq("t4_drop_busy",   32'(busy),        32'd1);
    chk_eq("t4_drop_wvalid", 32'(fifo_wvalid), 32'd0);
    cyc();
    req_valid = 4'b1011;
    #1;
    chk_eq("t4_grant1", 32'(grant), 32'h2);
    // Requester 1 bursts 4 beats, then the search from 2 lands on 3
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        cyc();
        #1;
      end
      chk_eq("t4_rr_src", 32'(fifo_src), 32'(i < 4 ? 1 : 3));
    end

    // T5: reset mid-burst, then restart from requester 0 with fresh beat count
    do_reset();
    dat[0]    = 4'd5;
    req_valid = 4'b0001;
    repeat (3) cyc();
    reset_n = 1'b0;
    #1;
    chk_eq("t5_rst_wvalid", 32'(fifo_wvalid), 32'd0);
    chk_eq("t5_rst_busy",   32'(busy),        32'd0);
    chk_eq("t5_rst_grant",  32'(grant),       32'd0);
    chk_eq("t5_rst_ready",  32'(req_ready),   32'd0);
    chk_eq("t5_rst_data",   32'(fifo_data),   32'd0);
    req_valid = 4'b0011;
    #1;
    reset_n = 1'b1;
    #1;
    chk_eq("t5_rel_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk_eq("t5_src", 32'(fifo_src), 32'(i < 4 ? 0 : 1));
    end

    // T6: random traffic with per-requester scoreboard
    do_reset();
    for (int k = 0; k < NumReq; k++) seq[k] = 0;
    beats   = 0;
    fifo_hs = 0;
    cycles  = 0;
    while (beats < 1000 && cycles < 20000) begin
      req_valid   = 4'($urandom_range(0, 15));
      fifo_wready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NumReq; k++) dat[k] = seq[k][3:0];
      #1;
      chk_eq("t6_ready_1hot", 32'($onehot0(req_ready)), 32'd1);
      if (busy) chk_eq("t6_grant_src", 32'(grant), 32'(1 << fifo_src));
      if (fifo_wvalid && fifo_wready) fifo_hs++;
      for (int k = 0; k < NumReq; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          chk_eq("t6_src",  32'(fifo_src),  32'(k));
          chk_eq("t6_data", 32'(fifo_data), 32'(seq[k] & 15));
          seq[k]++;
          beats++;
        end
      end
      cyc();
      cycles++;
    end
    chk_eq("t6_beats_done", 32'(beats >= 1000), 32'd1);
    chk_eq("t6_hs_match",   32'(fifo_hs),       32'(beats));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
